// File: rtl/sbu_stream_rr_arbiter.sv
// sbu_stream_rr_arbiter
// Packet-granular round-robin merge of two AXI4-Stream sources (s0, s1) onto a
// single registered egress port (m). A grant is held from the first beat of a
// packet through its tlast beat; the other source is ignored meanwhile.
// Per-source accepted-packet counters are exported; they wrap at 2^CNT_W.
//
// Optional build macro: FW_ARB_DROP_EN
//   When defined, an s0 packet whose first beat carries tuser[0]=0 (firewall
//   verdict "drop") is swallowed: s0 is held ready for the whole packet, no
//   beat reaches m, and drop_cnt0 counts it. When undefined, tuser is only
//   passed through and drop_cnt0 reads 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet in flight; arbitrate between s0 and s1 on a first beat
// PKT0  | s0 holds the grant until its tlast beat is accepted
// PKT1  | s1 holds the grant until its tlast beat is accepted
// DROP0 | (FW_ARB_DROP_EN only) s0 packet being discarded through tlast

module sbu_stream_rr_arbiter #(
    parameter int DATA_W = 256,
    parameter int USER_W = 12,
    parameter int ID_W   = 3,
    parameter int CNT_W  = 32
) (
    input  logic                mlx2sbu_clk,
    input  logic                mlx2sbu_reset,

    input  logic                s0_axi4stream_vld,
    output logic                s0_axi4stream_rdy,
    input  logic [DATA_W-1:0]   s0_axi4stream_tdata,
    input  logic [DATA_W/8-1:0] s0_axi4stream_tkeep,
    input  logic                s0_axi4stream_tlast,
    input  logic [USER_W-1:0]   s0_axi4stream_tuser,
    input  logic [ID_W-1:0]     s0_axi4stream_tid,

    input  logic                s1_axi4stream_vld,
    output logic                s1_axi4stream_rdy,
    input  logic [DATA_W-1:0]   s1_axi4stream_tdata,
    input  logic [DATA_W/8-1:0] s1_axi4stream_tkeep,
    input  logic                s1_axi4stream_tlast,
    input  logic [USER_W-1:0]   s1_axi4stream_tuser,
    input  logic [ID_W-1:0]     s1_axi4stream_tid,

    output logic                m_axi4stream_vld,
    input  logic                m_axi4stream_rdy,
    output logic [DATA_W-1:0]   m_axi4stream_tdata,
    output logic [DATA_W/8-1:0] m_axi4stream_tkeep,
    output logic                m_axi4stream_tlast,
    output logic [USER_W-1:0]   m_axi4stream_tuser,
    output logic [ID_W-1:0]     m_axi4stream_tid,

    output logic [CNT_W-1:0]    pkt_cnt0,
    output logic [CNT_W-1:0]    pkt_cnt1,
    output logic [CNT_W-1:0]    drop_cnt0
);

    localparam int KEEP_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PKT0  = 2'd1;
    localparam logic [1:0] ST_PKT1  = 2'd2;
`ifdef FW_ARB_DROP_EN
    localparam logic [1:0] ST_DROP0 = 2'd3;
`endif

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              last_grant_q;
    logic              last_grant_d;

    logic              sel0;
    logic              sel1;
    logic              slot_free;
    logic              drop_path;
    logic              acc0;
    logic              acc1;
    logic              fwd0;
    logic              load;

    logic              m_vld_q;
    logic [DATA_W-1:0] m_tdata_q;
    logic [KEEP_W-1:0] m_tkeep_q;
    logic              m_tlast_q;
    logic [USER_W-1:0] m_tuser_q;
    logic [ID_W-1:0]   m_tid_q;

    logic [CNT_W-1:0]  pkt_cnt0_q;
    logic [CNT_W-1:0]  pkt_cnt1_q;

    // The output register can take a beat when empty or when it drains this cycle.
    assign slot_free = ~m_vld_q | m_axi4stream_rdy;

    // Source selection: round-robin on a first beat, locked to the owner mid-packet.
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_axi4stream_vld && s1_axi4stream_vld) begin
                    // Tie goes to whichever source did not finish the last packet.
                    sel0 = last_grant_q;
                    sel1 = ~last_grant_q;
                end else begin
                    sel0 = s0_axi4stream_vld;
                    sel1 = s1_axi4stream_vld;
                end
            end
            ST_PKT0: sel0 = 1'b1;
            ST_PKT1: sel1 = 1'b1;
`ifdef FW_ARB_DROP_EN
            ST_DROP0: sel0 = 1'b1;
`endif
            default: begin
                sel0 = 1'b0;
                sel1 = 1'b0;
            end
        endcase
    end

`ifdef FW_ARB_DROP_EN
    // Only the first beat's verdict matters; once in DROP0 the whole packet is discarded.
    assign drop_path = (state_q == ST_DROP0) |
                       ((state_q == ST_IDLE) & sel0 & ~s0_axi4stream_tuser[0]);
`else
    assign drop_path = 1'b0;
`endif

    // Discarded beats never touch the output register, so they ignore slot_free.
    assign s0_axi4stream_rdy = drop_path | (slot_free & sel0);
    assign s1_axi4stream_rdy = slot_free & sel1;

    assign acc0 = s0_axi4stream_vld & s0_axi4stream_rdy;
    assign acc1 = s1_axi4stream_vld & s1_axi4stream_rdy;
    assign fwd0 = acc0 & ~drop_path;
    assign load = fwd0 | acc1;

    // Next-state and round-robin pointer update, driven only by accepted beats.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (acc0) begin
`ifdef FW_ARB_DROP_EN
                    if (drop_path) begin
                        state_d = s0_axi4stream_tlast ? ST_IDLE : ST_DROP0;
                    end else begin
                        state_d = s0_axi4stream_tlast ? ST_IDLE : ST_PKT0;
                    end
`else
                    state_d = s0_axi4stream_tlast ? ST_IDLE : ST_PKT0;
`endif
                end else if (acc1) begin
                    state_d = s1_axi4stream_tlast ? ST_IDLE : ST_PKT1;
                end
            end
            ST_PKT0: begin
                if (acc0 && s0_axi4stream_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT1: begin
                if (acc1 && s1_axi4stream_tlast) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FW_ARB_DROP_EN
            ST_DROP0: begin
                if (acc0 && s0_axi4stream_tlast) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (acc0 && s0_axi4stream_tlast) begin
            last_grant_d = 1'b0;
        end else if (acc1 && s1_axi4stream_tlast) begin
            last_grant_d = 1'b1;
        end
    end

    // State register; last_grant resets to 1 so s0 wins the first tie.
    always_ff @(posedge mlx2sbu_clk) begin
        if (mlx2sbu_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Egress register: load on every forwarded beat, clear valid only when drained idle.
    always_ff @(posedge mlx2sbu_clk) begin
        if (mlx2sbu_reset) begin
            m_vld_q   <= 1'b0;
            m_tdata_q <= '0;
            m_tkeep_q <= '0;
            m_tlast_q <= 1'b0;
            m_tuser_q <= '0;
            m_tid_q   <= '0;
        end else if (load) begin
            m_vld_q <= 1'b1;
            if (acc1) begin
                m_tdata_q <= s1_axi4stream_tdata;
                m_tkeep_q <= s1_axi4stream_tkeep;
                m_tlast_q <= s1_axi4stream_tlast;
                m_tuser_q <= s1_axi4stream_tuser;
                m_tid_q   <= s1_axi4stream_tid;
            end else begin
                m_tdata_q <= s0_axi4stream_tdata;
                m_tkeep_q <= s0_axi4stream_tkeep;
                m_tlast_q <= s0_axi4stream_tlast;
                m_tuser_q <= s0_axi4stream_tuser;
                m_tid_q   <= s0_axi4stream_tid;
            end
        end else if (m_axi4stream_rdy) begin
            m_vld_q <= 1'b0;
        end
    end

    assign m_axi4stream_vld   = m_vld_q;
    assign m_axi4stream_tdata = m_tdata_q;
    assign m_axi4stream_tkeep = m_tkeep_q;
    assign m_axi4stream_tlast = m_tlast_q;
    assign m_axi4stream_tuser = m_tuser_q;
    assign m_axi4stream_tid   = m_tid_q;

    // Forwarded-packet counters, bumped on the accepted tlast beat; free-running wrap.
    always_ff @(posedge mlx2sbu_clk) begin
        if (mlx2sbu_reset) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            if (fwd0 && s0_axi4stream_tlast) begin
                pkt_cnt0_q <= pkt_cnt0_q + CNT_ONE;
            end
            if (acc1 && s1_axi4stream_tlast) begin
                pkt_cnt1_q <= pkt_cnt1_q + CNT_ONE;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

`ifdef FW_ARB_DROP_EN
    logic [CNT_W-1:0] drop_cnt0_q;

    // Discarded-packet counter, bumped when the dropped packet's tlast is swallowed.
    always_ff @(posedge mlx2sbu_clk) begin
        if (mlx2sbu_reset) begin
            drop_cnt0_q <= '0;
        end else if (acc0 && drop_path && s0_axi4stream_tlast) begin
            drop_cnt0_q <= drop_cnt0_q + CNT_ONE;
        end
    end

    assign drop_cnt0 = drop_cnt0_q;
`else
    assign drop_cnt0 = '0;
`endif

endmodule

// File: tb/tb_sbu_stream_rr_arbiter.sv
// Bench for sbu_stream_rr_arbiter. Expected egress beats are queued in the order
// the arbitration rules dictate and compared as they leave the DUT. A second
// instance with 2-bit counters shares all inputs to exercise counter wrap.

module tb_sbu_stream_rr_arbiter;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [11:0]  user;
        logic [2:0]   id;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         s0_vld, s0_rdy, s0_tlast;
    logic [255:0] s0_tdata;
    logic [31:0]  s0_tkeep;
    logic [11:0]  s0_tuser;
    logic [2:0]   s0_tid;
    logic         s1_vld, s1_rdy, s1_tlast;
    logic [255:0] s1_tdata;
    logic [31:0]  s1_tkeep;
    logic [11:0]  s1_tuser;
    logic [2:0]   s1_tid;
    logic         m_vld, m_rdy, m_tlast;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic [11:0]  m_tuser;
    logic [2:0]   m_tid;
    logic [31:0]  pkt_cnt0, pkt_cnt1, drop_cnt0;

    logic         sm_s0_rdy, sm_s1_rdy, sm_m_vld, sm_m_tlast;
    logic [255:0] sm_m_tdata;
    logic [31:0]  sm_m_tkeep;
    logic [11:0]  sm_m_tuser;
    logic [2:0]   sm_m_tid;
    logic [1:0]   sm_pkt_cnt0, sm_pkt_cnt1, sm_drop_cnt0;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    beat_t sb[$];
    int    first_acc[2];
    int    last_acc[2];
    int    acc_cnt[2];
    int    acc_first_any;
    int    acc_last_any;
    int    last_out_cyc;
    int    exp_pkt0, exp_pkt1, exp_drop;

    sbu_stream_rr_arbiter dut (
        .mlx2sbu_clk(clk), .mlx2sbu_reset(rst),
        .s0_axi4stream_vld(s0_vld), .s0_axi4stream_rdy(s0_rdy), .s0_axi4stream_tdata(s0_tdata),
        .s0_axi4stream_tkeep(s0_tkeep), .s0_axi4stream_tlast(s0_tlast), .s0_axi4stream_tuser(s0_tuser),
        .s0_axi4stream_tid(s0_tid),
        .s1_axi4stream_vld(s1_vld), .s1_axi4stream_rdy(s1_rdy), .s1_axi4stream_tdata(s1_tdata),
        .s1_axi4stream_tkeep(s1_tkeep), .s1_axi4stream_tlast(s1_tlast), .s1_axi4stream_tuser(s1_tuser),
        .s1_axi4stream_tid(s1_tid),
        .m_axi4stream_vld(m_vld), .m_axi4stream_rdy(m_rdy), .m_axi4stream_tdata(m_tdata),
        .m_axi4stream_tkeep(m_tkeep), .m_axi4stream_tlast(m_tlast), .m_axi4stream_tuser(m_tuser),
        .m_axi4stream_tid(m_tid),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt0(drop_cnt0)
    );

    sbu_stream_rr_arbiter #(.CNT_W(2)) dut_small (
        .mlx2sbu_clk(clk), .mlx2sbu_reset(rst),
        .s0_axi4stream_vld(s0_vld), .s0_axi4stream_rdy(sm_s0_rdy), .s0_axi4stream_tdata(s0_tdata),
        .s0_axi4stream_tkeep(s0_tkeep), .s0_axi4stream_tlast(s0_tlast), .s0_axi4stream_tuser(s0_tuser),
        .s0_axi4stream_tid(s0_tid),
        .s1_axi4stream_vld(s1_vld), .s1_axi4stream_rdy(sm_s1_rdy), .s1_axi4stream_tdata(s1_tdata),
        .s1_axi4stream_tkeep(s1_tkeep), .s1_axi4stream_tlast(s1_tlast), .s1_axi4stream_tuser(s1_tuser),
        .s1_axi4stream_tid(s1_tid),
        .m_axi4stream_vld(sm_m_vld), .m_axi4stream_rdy(m_rdy), .m_axi4stream_tdata(sm_m_tdata),
        .m_axi4stream_tkeep(sm_m_tkeep), .m_axi4stream_tlast(sm_m_tlast), .m_axi4stream_tuser(sm_m_tuser),
        .m_axi4stream_tid(sm_m_tid),
        .pkt_cnt0(sm_pkt_cnt0), .pkt_cnt1(sm_pkt_cnt1), .drop_cnt0(sm_drop_cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Egress scoreboard: every valid cycle must show the oldest expected beat,
    // which also proves the payload holds steady while stalled.
    always @(negedge clk) begin
        if (!rst && m_vld) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got beat data=%h tlast=%0b, required no beat", m_tdata, m_tlast);
            end else begin
                if ({m_tdata, m_tkeep, m_tlast, m_tuser, m_tid} !== sb[0]) begin
                    n_errors++;
                    $display("FAIL out_beat: got data=%h keep=%h last=%0b user=%h id=%h, required data=%h keep=%h last=%0b user=%h id=%h",
                             m_tdata, m_tkeep, m_tlast, m_tuser, m_tid,
                             sb[0].data, sb[0].keep, sb[0].last, sb[0].user, sb[0].id);
                end
                if (m_rdy) begin
                    void'(sb.pop_front());
                    last_out_cyc = cyc + 1;
                end
            end
        end
    end

    function automatic beat_t make_beat(input int src, input int pkt, input int beat,
                                        input int n_beats, input logic user0);
        beat_t       b;
        logic [31:0] w;
        logic [31:0] k;
        w = {src[3:0], pkt[11:0], beat[7:0], 8'h3C};
        for (int i = 0; i < 8; i++) begin
            b.data[i*32 +: 32] = w ^ (32'h9E3779B9 * i);
        end
        b.last = (beat == n_beats - 1);
        k      = '1;
        b.keep = b.last ? (k >> (pkt % 8)) : k;
        b.user = {pkt[5:0], beat[3:0], src[0], (beat == 0) ? user0 : beat[0]};
        b.id   = {src[0], pkt[1:0]};
        return b;
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int n_beats, input logic user0);
        for (int b = 0; b < n_beats; b++) sb.push_back(make_beat(src, pkt, b, n_beats, user0));
    endtask

    task automatic set_src(input int src, input logic vld, input beat_t b);
        if (src == 0) begin
            s0_vld = vld; s0_tdata = b.data; s0_tkeep = b.keep;
            s0_tlast = b.last; s0_tuser = b.user; s0_tid = b.id;
        end else begin
            s1_vld = vld; s1_tdata = b.data; s1_tkeep = b.keep;
            s1_tlast = b.last; s1_tuser = b.user; s1_tid = b.id;
        end
    endtask

    function automatic logic src_rdy(input int src);
        return (src == 0) ? s0_rdy : s1_rdy;
    endfunction

    task automatic clear_track();
        first_acc     = '{-1, -1};
        last_acc      = '{-1, -1};
        acc_cnt       = '{0, 0};
        acc_first_any = -1;
        acc_last_any  = -1;
        last_out_cyc  = -1;
    endtask

    // Presents packets back to back on one source; records the cycle of each accepted beat.
    task automatic send_pkts(input int src, input int pkt_base, input int n_pkts,
                             input int n_beats, input logic user0);
        beat_t b;
        bit    hs;
        int    waits;
        for (int p = 0; p < n_pkts; p++) begin
            for (int bt = 0; bt < n_beats; bt++) begin
                b = make_beat(src, pkt_base + p, bt, n_beats, user0);
                set_src(src, 1'b1, b);
                hs    = 1'b0;
                waits = 0;
                while (!hs && waits < 1000) begin
                    @(negedge clk);
                    hs = src_rdy(src);
                    @(posedge clk);
                    #1;
                    waits++;
                end
                if (!hs) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL handshake_timeout: s%0d rdy stayed 0 for %0d cycles, required 1", src, waits);
                    set_src(src, 1'b0, '0);
                    return;
                end
                if (first_acc[src] < 0) first_acc[src] = cyc;
                last_acc[src] = cyc;
                acc_cnt[src]++;
                if (acc_first_any < 0) acc_first_any = cyc;
                acc_last_any = cyc;
            end
        end
        set_src(src, 1'b0, '0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        m_rdy = 1'b1;
        while ((sb.size() != 0 || m_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || m_vld) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: %0d beats outstanding, m_vld=%0b, required 0 and 0", name, sb.size(), m_vld);
            sb.delete();
        end
    endtask

    task automatic check_counts(input string name);
        n_checks++;
        if (pkt_cnt0 !== exp_pkt0[31:0] || pkt_cnt1 !== exp_pkt1[31:0] || drop_cnt0 !== exp_drop[31:0]) begin
            n_errors++;
            $display("FAIL %s_counters: got pkt0=%0d pkt1=%0d drop0=%0d, required %0d %0d %0d",
                     name, pkt_cnt0, pkt_cnt1, drop_cnt0, exp_pkt0, exp_pkt1, exp_drop);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_src(0, 1'b0, '0);
        set_src(1, 1'b0, '0);
        m_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_pkt0 = 0; exp_pkt1 = 0; exp_drop = 0;
        clear_track();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rdy = 1'b0;
        set_src(0, 1'b0, '0);
        set_src(1, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (m_vld !== 1'b0 || {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid} !== '0) begin
            n_errors++;
            $display("FAIL reset_output: got m_vld=%0b tdata=%h, required 0 and 0", m_vld, m_tdata);
        end
        n_checks++;
        if (s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rdy: got s0_rdy=%0b s1_rdy=%0b, required 0 0", s0_rdy, s1_rdy);
        end
        exp_pkt0 = 0; exp_pkt1 = 0; exp_drop = 0;
        check_counts("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_rdy = 1'b1;
    endtask

    task automatic test_single_source();
        do_reset();
        push_pkt(0, 0, 4, 1); push_pkt(0, 1, 4, 1); push_pkt(0, 2, 4, 1);
        send_pkts(0, 0, 3, 4, 1);
        wait_drain("single");
        exp_pkt0 = 3;
        check_counts("single");
        n_checks++;
        if (acc_last_any - acc_first_any !== 11) begin
            n_errors++;
            $display("FAIL single_bubbles: 12 beats spanned %0d cycles, required 11", acc_last_any - acc_first_any);
        end
        n_checks++;
        if (last_out_cyc !== acc_last_any + 1) begin
            n_errors++;
            $display("FAIL single_latency: last beat out at cycle %0d, required %0d", last_out_cyc, acc_last_any + 1);
        end
    endtask

    task automatic test_contention();
        do_reset();
        push_pkt(0, 0, 2, 1); push_pkt(1, 0, 2, 1);
        push_pkt(0, 1, 2, 1); push_pkt(1, 1, 2, 1);
        fork
            send_pkts(0, 0, 2, 2, 1);
            send_pkts(1, 0, 2, 2, 1);
        join
        wait_drain("contention");
        exp_pkt0 = 2; exp_pkt1 = 2;
        check_counts("contention");
        n_checks++;
        if (acc_last_any - acc_first_any !== 7) begin
            n_errors++;
            $display("FAIL contention_back_to_back: 8 beats spanned %0d cycles, required 7", acc_last_any - acc_first_any);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        push_pkt(1, 5, 5, 1);
        push_pkt(0, 5, 3, 1);
        fork
            send_pkts(1, 5, 1, 5, 1);
            begin
                int n = 0;
                while (acc_cnt[1] < 1 && n < 100) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                send_pkts(0, 5, 1, 3, 1);
            end
            begin
                int n = 0;
                while (acc_cnt[1] < 5 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (s0_vld && acc_cnt[1] < 5) begin
                        n_checks++;
                        if (s0_rdy !== 1'b0) begin
                            n_errors++;
                            $display("FAIL no_preempt_rdy: s0_rdy=%0b while s1 owns packet, required 0", s0_rdy);
                        end
                    end
                end
            end
        join
        wait_drain("no_preempt");
        exp_pkt0 = 1; exp_pkt1 = 1;
        check_counts("no_preempt");
        n_checks++;
        if (first_acc[0] !== last_acc[1] + 1) begin
            n_errors++;
            $display("FAIL no_preempt_handover: s0 first beat at cycle %0d, required %0d", first_acc[0], last_acc[1] + 1);
        end
    endtask

    task automatic test_rdy_toggle();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit   done = 1'b0;
        do_reset();
        push_pkt(0, 9, 6, 1);
        fork
            begin
                send_pkts(0, 9, 1, 6, 1);
                done = 1'b1;
            end
            begin
                int k = 0;
                while (!done && k < 500) begin
                    m_rdy = pat[k % 4];
                    @(posedge clk);
                    #1;
                    k++;
                end
            end
        join
        wait_drain("rdy_toggle");
        exp_pkt0 = 1;
        check_counts("rdy_toggle");
    endtask

    task automatic test_hold();
        do_reset();
        m_rdy = 1'b0;
        push_pkt(0, 7, 3, 1);
        push_pkt(1, 7, 1, 1);
        fork
            send_pkts(0, 7, 1, 3, 1);
            send_pkts(1, 7, 1, 1, 1);
            begin
                repeat (5) @(negedge clk);
                n_checks++;
                if (s0_rdy !== 1'b0 || s1_rdy !== 1'b0 || m_vld !== 1'b1) begin
                    n_errors++;
                    $display("FAIL hold_stall: got s0_rdy=%0b s1_rdy=%0b m_vld=%0b, required 0 0 1", s0_rdy, s1_rdy, m_vld);
                end
                n_checks++;
                if (acc_cnt[0] !== 1 || acc_cnt[1] !== 0) begin
                    n_errors++;
                    $display("FAIL hold_accepts: got s0=%0d s1=%0d beats, required 1 0", acc_cnt[0], acc_cnt[1]);
                end
                @(posedge clk);
                #1;
                m_rdy = 1'b1;
            end
        join
        wait_drain("hold");
        exp_pkt0 = 1; exp_pkt1 = 1;
        check_counts("hold");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(0, 2, 3, 1);
        send_pkts(0, 2, 1, 3, 1);
        wait_drain("rst_mid_pre");
        exp_pkt0 = 1;
        check_counts("rst_mid_pre");
        @(posedge clk);
        #1;
        push_pkt(0, 3, 8, 1);
        for (int b = 0; b < 3; b++) begin
            set_src(0, 1'b1, make_beat(0, 3, b, 8, 1'b1));
            if (b == 2) rst = 1'b1;
            @(negedge clk);
            if (b < 2) begin
                n_checks++;
                if (s0_rdy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rst_mid_accept: beat %0d s0_rdy=%0b, required 1", b, s0_rdy);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        set_src(0, 1'b0, '0);
        sb.delete();
        exp_pkt0 = 0;
        @(negedge clk);
        n_checks++;
        if (m_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_vld: got m_vld=%0b after reset, required 0", m_vld);
        end
        check_counts("rst_mid_post");
        @(posedge clk);
        #1;
        clear_track();
        push_pkt(0, 4, 5, 1);
        send_pkts(0, 4, 1, 5, 1);
        wait_drain("rst_mid_new");
        exp_pkt0 = 1;
        check_counts("rst_mid_new");
    endtask

`ifdef FW_ARB_DROP_EN
    task automatic test_drop();
        do_reset();
        push_pkt(0, 1, 4, 1);
        send_pkts(0, 0, 1, 4, 1'b0);
        send_pkts(0, 1, 1, 4, 1'b1);
        wait_drain("drop");
        exp_pkt0 = 1; exp_drop = 1;
        check_counts("drop");
    endtask
`endif

    task automatic test_counter_wrap();
        do_reset();
        push_pkt(0, 0, 1, 1); push_pkt(0, 1, 1, 1); push_pkt(0, 2, 1, 1);
        send_pkts(0, 0, 3, 1, 1);
        wait_drain("wrap_pre");
        n_checks++;
        if (sm_pkt_cnt0 !== 2'd3) begin
            n_errors++;
            $display("FAIL wrap_max: got small pkt_cnt0=%0d, required 3", sm_pkt_cnt0);
        end
        @(posedge clk);
        #1;
        push_pkt(0, 3, 1, 1);
        send_pkts(0, 3, 1, 1, 1);
        wait_drain("wrap");
        n_checks++;
        if (sm_pkt_cnt0 !== 2'd0 || sm_pkt_cnt1 !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_zero: got small pkt_cnt0=%0d pkt_cnt1=%0d, required 0 0", sm_pkt_cnt0, sm_pkt_cnt1);
        end
        exp_pkt0 = 4;
        check_counts("wrap");
    endtask

    initial begin
        clear_track();
        test_reset();
        test_single_source();
        test_contention();
        test_no_preempt();
        test_rdy_toggle();
        test_hold();
        test_reset_mid_packet();
`ifdef FW_ARB_DROP_EN
        test_drop();
`endif
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
